// File: rtl/mp_pkg.sv
// Shared definitions for the 8-bit microprocessor: datapath widths, fetch-unit
// state encoding and the default filler instruction.
package mp_pkg;

  localparam int unsigned INSTR_W = 8;
  localparam int unsigned PC_W    = 8;

  localparam logic [INSTR_W-1:0] FILL_INSTR_DEF = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    EXEC,
    CAP,
    HALT
  } state_e;

endpackage

// File: rtl/step_sync.sv
// Two-flop synchroniser for the asynchronous step button plus a rising-edge
// detector producing a single-cycle pulse.
module step_sync (
  input  logic clk,
  input  logic reset,
  input  logic step,
  output logic stepRise
);

  // [0],[1] form the synchroniser; [2] remembers the previous synchronised level.
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], step};
    end
  end

  assign stepRise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: loads program memory over a byte stream, then paces
// the core with cpu_en strobes and stops on a branch-to-self.
module instr_fetch_unit
  import mp_pkg::*;
#(
  parameter int unsigned        DEPTH      = 16,
  parameter logic [INSTR_W-1:0] FILL_INSTR = FILL_INSTR_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               run_mode,
  input  logic               step,
  input  logic [PC_W-1:0]    nextPc,
  output logic [INSTR_W-1:0] instruction,
  output logic               cpu_en,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    prog_len,
  output logic               halted
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  // One extra bit so a full 256-entry memory can still be counted.
  localparam int unsigned CNT_W = PC_W + 1;

  logic [INSTR_W-1:0] mem [DEPTH];

  state_e           state;
  logic [CNT_W-1:0] load_cnt;
  logic             step_rise;
  logic             accept;
  logic             last_entry;
  logic             pc_in_range;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  step_sync u_step_sync (
    .clk      (clk),
    .reset    (reset),
    .step     (step),
    .stepRise (step_rise)
  );

  assign accept      = load_valid & load_ready;
  assign wr_idx      = load_cnt[IDX_W-1:0];
  assign rd_idx      = pc[IDX_W-1:0];
  assign last_entry  = (load_cnt == CNT_W'(DEPTH - 1));
  // Loaded count never exceeds DEPTH, so this also rejects pc >= DEPTH (no wrap).
  assign pc_in_range = ({1'b0, pc} < load_cnt);
  assign prog_len    = load_cnt[CNT_W-1] ? '1 : load_cnt[PC_W-1:0];

  // Program memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_idx] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      load_ready  <= 1'b0;
      instruction <= FILL_INSTR;
      cpu_en      <= 1'b0;
      pc          <= '0;
      load_cnt    <= '0;
      halted      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state      <= LOAD;
          load_ready <= 1'b1;
        end
        LOAD: begin
          if (accept) begin
            load_cnt <= load_cnt + 1'b1;
            if (load_last || last_entry) begin
              state      <= FETCH;
              load_ready <= 1'b0;
              pc         <= '0;
            end
          end
        end
        FETCH: begin
          instruction <= pc_in_range ? mem[rd_idx] : FILL_INSTR;
          if (run_mode || step_rise) begin
            state  <= EXEC;
            cpu_en <= 1'b1;
          end
        end
        EXEC: begin
          cpu_en <= 1'b0;
          state  <= CAP;
        end
        CAP: begin
          if (nextPc == pc) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            pc    <= nextPc;
            state <= FETCH;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: behavioural model compared every
// cycle, plus directed literal checks for the key scenarios.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH = 16;
  localparam logic [7:0]  FILL  = 8'h00;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_last = 1'b0;
  logic       load_ready;
  logic       run_mode = 1'b0;
  logic       step = 1'b0;
  logic [7:0] nextPc = 8'h00;
  logic [7:0] instruction;
  logic       cpu_en;
  logic [7:0] pc;
  logic [7:0] prog_len;
  logic       halted;

  instr_fetch_unit #(
    .DEPTH      (DEPTH),
    .FILL_INSTR (FILL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .run_mode    (run_mode),
    .step        (step),
    .nextPc      (nextPc),
    .instruction (instruction),
    .cpu_en      (cpu_en),
    .pc          (pc),
    .prog_len    (prog_len),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mMem [DEPTH];
  int  mLen, mPc, mInstr;
  bit  mReady, mEn, mHalt, mAwake, mRunning;
  int  mAge;            // -1: awaiting go, 0: strobe cycle, 1: core reports nextPc
  bit  [2:0] mStepSeen; // step levels sampled at the last three edges
  bit  mRise;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mLen = 0; mPc = 0; mInstr = FILL; mReady = 0; mEn = 0; mHalt = 0;
      mAwake = 0; mRunning = 0; mAge = -1; mStepSeen = '0;
    end else begin
      cyc++;
      // A rising step becomes usable two edges after it is first sampled.
      mRise = mStepSeen[1] && !mStepSeen[2];
      mStepSeen = {mStepSeen[1:0], step};
      if (!mAwake) begin
        mAwake = 1; mReady = 1;
      end else if (mReady) begin
        if (load_valid) begin
          mMem[mLen] = load_data;
          mLen++;
          if (load_last || mLen == DEPTH) begin
            mReady = 0; mRunning = 1; mPc = 0;
          end
        end
      end else if (mRunning && !mHalt) begin
        if (mAge == 0) begin
          mEn = 0; mAge = 1;
        end else if (mAge == 1) begin
          if (int'(nextPc) == mPc) mHalt = 1;
          else mPc = int'(nextPc);
          mAge = -1;
        end else begin
          mInstr = (mPc < mLen) ? int'(mMem[mPc]) : int'(FILL);
          if (run_mode || mRise) begin
            mEn = 1; mAge = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("load_ready", int'(load_ready), int'(mReady));
    check("instruction", int'(instruction), mInstr);
    check("cpu_en", int'(cpu_en), int'(mEn));
    check("pc", int'(pc), mPc);
    check("prog_len", int'(prog_len), mLen);
    check("halted", int'(halted), int'(mHalt));
  end

  // ---------------- core model driving nextPc ----------------
  int corePolicy = 0;
  bit sawFive = 0;
  int rpc;

  always @(negedge clk) begin
    if (mPc == 5) sawFive = 1;
    case (corePolicy)
      0: nextPc = 8'(mPc + 1);
      1: nextPc = (mPc == 5) ? 8'd2 : ((mPc == 2 && sawFive) ? 8'd2 : 8'(mPc + 1));
      default: begin
        rpc = int'($urandom_range(0, 19));
        if (rpc == mPc) rpc++;
        nextPc = 8'(rpc);
      end
    endcase
  end

  // ---------------- stimulus ----------------
  logic [7:0] progBuf [32];

  task automatic waitReady();
    for (int n = 0; n < 20 && !load_ready; n++) @(negedge clk);
    check("ready_wait", int'(load_ready), 1);
  endtask

  task automatic resetDut();
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    waitReady();
  endtask

  task automatic loadProg(input int n, input bit gaps);
    int sent = 0;
    bit acc;
    for (int guard = 0; sent < n && guard < 200; guard++) begin
      load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      load_data  = progBuf[sent];
      load_last  = (sent == n - 1);
      acc = load_valid && load_ready;
      @(negedge clk);
      if (acc) sent++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("load_complete", sent, n);
  endtask

  int lastEn, ens;

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_load_ready", int'(load_ready), 0);
    check("rst_instruction", int'(instruction), 0);
    check("rst_cpu_en", int'(cpu_en), 0);
    check("rst_pc", int'(pc), 0);
    check("rst_prog_len", int'(prog_len), 0);
    check("rst_halted", int'(halted), 0);
    #2 reset = 1'b1;
    @(negedge clk);
    waitReady();

    // Load 41 52 63 74, then free-run with a core that loops 5->2 and halts at 2.
    progBuf[0] = 8'h41; progBuf[1] = 8'h52; progBuf[2] = 8'h63; progBuf[3] = 8'h74;
    run_mode = 1'b1;
    corePolicy = 1;
    loadProg(4, 1'b0);
    check("t1_ready_low", int'(load_ready), 0);
    check("t1_prog_len", int'(prog_len), 4);
    @(negedge clk);
    check("t1_instr", int'(instruction), 8'h41);
    check("t1_pc", int'(pc), 0);
    check("t1_cpu_en", int'(cpu_en), 1);
    lastEn = cyc;
    for (int i = 0; i < 80 && !halted; i++) begin
      @(negedge clk);
      if (cpu_en) begin
        check("t2_period", cyc - lastEn, 3);
        lastEn = cyc;
        if (pc == 8'd1) check("t2_instr_pc1", int'(instruction), 8'h52);
        if (pc == 8'd4) check("t2_fill_pc4", int'(instruction), 8'h00);
      end
    end
    check("t3_halted", int'(halted), 1);
    check("t3_pc", int'(pc), 2);
    ens = 0;
    repeat (20) begin
      @(negedge clk);
      if (cpu_en) ens++;
    end
    check("t3_no_en", ens, 0);
    check("t3_pc_held", int'(pc), 2);
    check("t3_instr_held", int'(instruction), 8'h63);

    // Single-step with random program and random core jumps.
    resetDut();
    run_mode = 1'b0;
    corePolicy = 2;
    for (int i = 0; i < 6; i++) progBuf[i] = 8'($urandom);
    loadProg(6, 1'b1);
    ens = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_en) ens++;
    end
    check("t4_idle_no_en", ens, 0);
    step = 1'b1;
    ens = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_en) ens++;
    end
    check("t4_one_en_held", ens, 1);
    step = 1'b0;
    ens = 0;
    repeat (5) begin
      @(negedge clk);
      if (cpu_en) ens++;
    end
    check("t4_low_no_en", ens, 0);
    step = 1'b1;
    ens = 0;
    repeat (8) begin
      @(negedge clk);
      if (cpu_en) ens++;
    end
    check("t4_second_en", ens, 1);
    repeat (400) begin
      run_mode = ($urandom_range(0, 3) == 0);
      step = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    step = 1'b0;

    // Overfill: DEPTH+3 bytes with no last flag.
    resetDut();
    run_mode = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      load_valid = 1'b1;
      load_data  = 8'($urandom);
      load_last  = 1'b0;
      @(negedge clk);
      if (i == DEPTH - 1) check("t5_ready_after_full", int'(load_ready), 0);
    end
    load_valid = 1'b0;
    check("t5_prog_len", int'(prog_len), DEPTH);
    repeat (150) @(negedge clk);

    // Reset asserted while the strobe is high.
    for (int i = 0; i < 20 && !cpu_en; i++) @(negedge clk);
    check("t6_exec_seen", int'(cpu_en), 1);
    #2 reset = 1'b0;
    #1;
    check("t6_cpu_en", int'(cpu_en), 0);
    check("t6_load_ready", int'(load_ready), 0);
    check("t6_pc", int'(pc), 0);
    check("t6_prog_len", int'(prog_len), 0);
    check("t6_instr", int'(instruction), 0);
    check("t6_halted", int'(halted), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("t6_ready_after_idle", int'(load_ready), 1);
    for (int i = 0; i < 3; i++) progBuf[i] = 8'($urandom);
    loadProg(3, 1'b0);
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

endmodule
